writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Write-side master of register_file: arbitrates results from the ALU and load/store paths, aligns and extends load data, and drives we/rd_addr/rd into the register file one cycle after acceptance.
- Also exposes the in-flight write as a forwarding source for decode, since the register file commits only on the next clock edge.

Parameters:
DATA_WIDTH, 32 (pkg_config), datapath width
NUM_REGISTER, 32 (pkg_config), architectural registers; address width AW = $clog2(NUM_REGISTER)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU result accepted this cycle
alu_rd_addr_i  in  AW  ALU destination
alu_data_i  in  DATA_WIDTH  ALU result
lsu_valid_i  in  1  load result valid
lsu_ready_o  out  1  load result accepted this cycle
lsu_rd_addr_i  in  AW  load destination
lsu_data_i  in  DATA_WIDTH  raw aligned memory word
lsu_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
lsu_offset_i  in  2  byte address bits [1:0]
we_o  out  1  register-file write enable
rd_addr_o  out  AW  register-file write address
rd_o  out  DATA_WIDTH  register-file write data
fwd_valid_o  out  1  equals we_o; forwarding entry valid
fwd_addr_o  out  AW  equals rd_addr_o
fwd_data_o  out  DATA_WIDTH  equals rd_o
load_err_o  out  1  one-cycle pulse: misaligned or illegal load dropped
retire_cnt_o  out  32  committed-write counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n_i low): we_o=0, rd_addr_o=0, rd_o=0, load_err_o=0, retire_cnt_o=0, last_grant=ALU (so LSU wins the first contest).
- Registered outputs only; no stall path, because the register file accepts every cycle.
- Arbitration, one grant per cycle; ready_o is combinational:
  - Only one valid: grant it.
  - Both valid: grant the source not granted last (round-robin); last_grant updates on every grant.
  - Non-granted source sees ready=0 and holds its inputs.
- Latency: grant at edge N, so we_o/rd_addr_o/rd_o are valid during cycle N+1 and the register file writes at edge N+1.
- No grant in a cycle: we_o=0 next cycle; rd_addr_o/rd_o hold their previous values.
- Load formatting, byte lane = lsu_offset_i:
  - LB/LBU: select byte, sign-/zero-extend.
  - LH/LHU: select halfword at offset 0 or 2, sign-/zero-extend.
  - LW: whole word.
- Error cases: LH/LHU with offset 1 or 3, LW with offset != 0, or funct3 in {011,110,111}:
  - Still accepted (ready=1).
  - No write: we_o=0 next cycle.
  - load_err_o=1 for one cycle.
- x0: a granted result with rd_addr=0 is accepted, but we_o stays 0 next cycle and the retire counter does not increment.
- Simultaneous ALU/LSU targeting the same rd: serialized by arbitration; the later grant overwrites. No merging.
- Reset mid-operation: the in-flight write is discarded; we_o drops immediately (asynchronous).

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_cnt_o is a 32-bit counter, +1 on each cycle with we_o=1, wraps 0xFFFF_FFFF to 0, cleared by reset.
- Undefined: no counter flops; retire_cnt_o tied to 0.

Test Plan:
- Reset released, then ALU valid with rd=5, data=0x0000_1234 -> alu_ready_o=1 same cycle; next cycle we_o=1, rd_addr_o=5, rd_o=0x0000_1234, fwd_* identical.
- ALU and LSU valid together for 3 cycles after reset -> grants LSU, ALU, LSU; we_o asserted 3 consecutive cycles in that order.
- LSU word 0x8081_82F3, LB offset 0 -> 0xFFFF_FFF3; LBU offset 3 -> 0x0000_0080; LH offset 2 -> 0xFFFF_8081; LHU offset 0 -> 0x0000_82F3.
- LW offset 2, and funct3=011 offset 0 -> accepted, load_err_o pulses 1 cycle, we_o=0; retire count unchanged.
- ALU write rd=0, data=0xDEAD_BEEF -> alu_ready_o=1, we_o stays 0; with WB_RETIRE_CNT_EN, retire_cnt_o unchanged.
- rst_n_i asserted the cycle after a grant -> we_o drops to 0 immediately, and retire_cnt_o=0.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: round-robin arbitration of ALU/LSU results, load formatting, registered RF write port + forwarding.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN; otherwise retire_cnt_o is tied to 0.
module writeback_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGISTER = 32,
  localparam int AW          = $clog2(NUM_REGISTER)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [AW-1:0]         alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [AW-1:0]         lsu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [1:0]            lsu_offset_i,
  output logic                  we_o,
  output logic [AW-1:0]         rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  fwd_valid_o,
  output logic [AW-1:0]         fwd_addr_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  load_err_o,
  output logic [31:0]           retire_cnt_o
);

  typedef struct packed {
    logic                  wr;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic last_lsu;  // 1: LSU granted most recently
  logic grant_alu, grant_lsu;

  // Reset leaves last_lsu=0 so the LSU wins the first contest.
  always_comb begin
    grant_lsu = lsu_valid_i & (~alu_valid_i | ~last_lsu);
    grant_alu = alu_valid_i & ~grant_lsu;
  end

  assign alu_ready_o = grant_alu;
  assign lsu_ready_o = grant_lsu;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_err;

  always_comb begin
    ld_byte = lsu_data_i[{lsu_offset_i, 3'b000} +: 8];
    ld_half = lsu_offset_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];
    ld_data = '0;
    ld_err  = 1'b0;
    unique case (lsu_funct3_i)
      F3_LB:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_LH: begin
        ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
        ld_err  = lsu_offset_i[0];
      end
      F3_LHU: begin
        ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
        ld_err  = lsu_offset_i[0];
      end
      F3_LW: begin
        ld_data = lsu_data_i;
        ld_err  = |lsu_offset_i;
      end
      default: ld_err = 1'b1;
    endcase
  end

  wb_req_t nxt;

  // Writes to x0 and malformed loads are consumed without touching the RF.
  always_comb begin
    nxt = '0;
    if (grant_alu) begin
      nxt.wr   = |alu_rd_addr_i;
      nxt.addr = alu_rd_addr_i;
      nxt.data = alu_data_i;
    end else if (grant_lsu) begin
      nxt.wr   = ~ld_err & (|lsu_rd_addr_i);
      nxt.addr = lsu_rd_addr_i;
      nxt.data = ld_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_o       <= 1'b0;
      rd_addr_o  <= '0;
      rd_o       <= '0;
      load_err_o <= 1'b0;
      last_lsu   <= 1'b0;
    end else begin
      we_o       <= nxt.wr;
      load_err_o <= grant_lsu & ld_err;
      if (nxt.wr) begin
        rd_addr_o <= nxt.addr;
        rd_o      <= nxt.data;
      end
      if (grant_alu | grant_lsu) last_lsu <= grant_lsu;
    end
  end

  assign fwd_valid_o = we_o;
  assign fwd_addr_o  = rd_addr_o;
  assign fwd_data_o  = rd_o;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  retire_cnt_q <= '0;
    else if (we_o) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign retire_cnt_o = retire_cnt_q;
`else
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed + random bench for writeback_unit against a spec-level reference model.
module tb_writeback_unit;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i, lsu_ready_o;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_data_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_offset_i;
  logic        we_o, fwd_valid_o, load_err_o;
  logic [4:0]  rd_addr_o, fwd_addr_o;
  logic [31:0] rd_o, fwd_data_o, retire_cnt_o;

  writeback_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_addr_i(alu_rd_addr_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_funct3_i(lsu_funct3_i), .lsu_offset_i(lsu_offset_i),
    .we_o(we_o), .rd_addr_o(rd_addr_o), .rd_o(rd_o),
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
    .load_err_o(load_err_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // reference state
  bit          m_last_lsu;
  bit          m_we, m_err, m_known;
  logic [4:0]  m_addr;
  logic [31:0] m_rd;
  int unsigned m_cnt;
  bit          g_alu, g_lsu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off, output bit err);
    logic [31:0] b, h;
    b = (w >> (int'(off) * 8)) & 32'hFF;
    h = (w >> (int'(off) * 8)) & 32'hFFFF;
    err = 1'b0;
    case (f3)
      3'b000: return (b & 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b100: return b;
      3'b001: begin err = (off == 1 || off == 3); return (h & 32'h8000) ? (h | 32'hFFFF_0000) : h; end
      3'b101: begin err = (off == 1 || off == 3); return h; end
      3'b010: begin err = (off != 0); return w; end
      default: begin err = 1'b1; return 32'h0; end
    endcase
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".we"}, {31'b0, we_o}, {31'b0, m_we});
    chk({tag, ".err"}, {31'b0, load_err_o}, {31'b0, m_err});
    chk({tag, ".cnt"}, retire_cnt_o, exp_cnt());
    chk({tag, ".fwd_v"}, {31'b0, fwd_valid_o}, {31'b0, m_we});
    if (m_known) begin
      chk({tag, ".addr"}, {27'b0, rd_addr_o}, {27'b0, m_addr});
      chk({tag, ".rd"}, rd_o, m_rd);
      chk({tag, ".fwd_a"}, {27'b0, fwd_addr_o}, {27'b0, m_addr});
      chk({tag, ".fwd_d"}, fwd_data_o, m_rd);
    end
  endtask

  // Inputs already driven (at negedge); check readies, clock once, check outputs.
  task automatic step(input string tag);
    bit e;
    logic [31:0] v;
    #1;
    g_lsu = lsu_valid_i && (!alu_valid_i || !m_last_lsu);
    g_alu = alu_valid_i && !g_lsu;
    chk({tag, ".alu_rdy"}, {31'b0, alu_ready_o}, {31'b0, g_alu});
    chk({tag, ".lsu_rdy"}, {31'b0, lsu_ready_o}, {31'b0, g_lsu});
    v = fmt_load(lsu_data_i, lsu_funct3_i, lsu_offset_i, e);
    @(posedge clk_i);
    if (m_we) m_cnt++;
    if (g_alu || g_lsu) m_last_lsu = g_lsu;
    m_err = g_lsu && e;
    m_we  = 1'b0;
    if (g_alu && alu_rd_addr_i != 0) begin
      m_we = 1'b1; m_addr = alu_rd_addr_i; m_rd = alu_data_i; m_known = 1'b1;
    end else if (g_lsu && !e && lsu_rd_addr_i != 0) begin
      m_we = 1'b1; m_addr = lsu_rd_addr_i; m_rd = v; m_known = 1'b1;
    end else if (g_alu || g_lsu) begin
      m_known = 1'b0;  // accepted without a write: address/data not specified
    end
    #1;
    check_outputs(tag);
    @(negedge clk_i);
  endtask

  task automatic idle();
    alu_valid_i = 0; lsu_valid_i = 0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    alu_valid_i = 1; alu_rd_addr_i = a; alu_data_i = d;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off);
    lsu_valid_i = 1; lsu_rd_addr_i = a; lsu_data_i = d; lsu_funct3_i = f3; lsu_offset_i = off;
  endtask

  task automatic do_reset();
    rst_n_i = 0;
    idle();
    m_last_lsu = 0; m_we = 0; m_err = 0; m_addr = 0; m_rd = 0; m_cnt = 0; m_known = 1;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1;
    @(negedge clk_i);
  endtask

  int unsigned cnt_before;

  initial begin
    alu_rd_addr_i = 0; alu_data_i = 0; lsu_rd_addr_i = 0; lsu_data_i = 0;
    lsu_funct3_i = 0; lsu_offset_i = 0;
    do_reset();
    check_outputs("reset");

    // single ALU write
    alu(5'd5, 32'h0000_1234); step("alu5");
    chk("alu5.rd_const", rd_o, 32'h0000_1234);
    idle(); step("hold");

    // contention after reset: LSU, ALU, LSU
    do_reset();
    alu(5'd8, 32'hAAAA_0008);
    lsu(5'd7, 32'h7777_0007, 3'b010, 2'd0);
    step("rr0"); chk("rr0.addr_const", {27'b0, rd_addr_o}, 32'd7);
    step("rr1"); chk("rr1.addr_const", {27'b0, rd_addr_o}, 32'd8);
    step("rr2"); chk("rr2.addr_const", {27'b0, rd_addr_o}, 32'd7);
    idle();

    // load formatting
    lsu(5'd9, 32'h8081_82F3, 3'b000, 2'd0); alu_valid_i = 0; step("lb0");
    chk("lb0.const", rd_o, 32'hFFFF_FFF3);
    lsu(5'd9, 32'h8081_82F3, 3'b100, 2'd3); step("lbu3");
    chk("lbu3.const", rd_o, 32'h0000_0080);
    lsu(5'd9, 32'h8081_82F3, 3'b001, 2'd2); step("lh2");
    chk("lh2.const", rd_o, 32'hFFFF_8081);
    lsu(5'd9, 32'h8081_82F3, 3'b101, 2'd0); step("lhu0");
    chk("lhu0.const", rd_o, 32'h0000_82F3);

    // illegal / misaligned loads
    idle(); step("pre_err");
    cnt_before = retire_cnt_o;
    lsu(5'd10, 32'h1234_5678, 3'b010, 2'd2); step("lw_mis");
    chk("lw_mis.err_const", {31'b0, load_err_o}, 32'd1);
    lsu(5'd10, 32'h1234_5678, 3'b011, 2'd0); step("f3_011");
    idle(); step("err_clear");
    chk("err_clear.err_const", {31'b0, load_err_o}, 32'd0);
    chk("err.cnt_unchanged", retire_cnt_o, cnt_before);

    // x0 write is consumed silently
    cnt_before = retire_cnt_o;
    alu(5'd0, 32'hDEAD_BEEF); step("x0");
    idle(); step("x0_after");
    chk("x0.cnt_unchanged", retire_cnt_o, cnt_before);

    // random traffic, non-granted source holds its inputs
    for (int i = 0; i < 300; i++) begin
      if (!alu_valid_i || g_alu) begin
        alu_valid_i = ($urandom_range(0, 3) != 0);
        alu_rd_addr_i = 5'($urandom_range(0, 31));
        alu_data_i = $urandom;
      end
      if (!lsu_valid_i || g_lsu) begin
        lsu_valid_i = ($urandom_range(0, 3) != 0);
        lsu_rd_addr_i = 5'($urandom_range(0, 31));
        lsu_data_i = $urandom;
        lsu_funct3_i = 3'($urandom_range(0, 7));
        lsu_offset_i = 2'($urandom_range(0, 3));
      end
      step("rand");
    end

    // reset in the cycle after a grant
    idle(); alu(5'd3, 32'h0303_0303); step("pre_rst");
    idle();
    rst_n_i = 0;
    #1;
    chk("midrst.we", {31'b0, we_o}, 32'd0);
    chk("midrst.cnt", retire_cnt_o, 32'd0);
    do_reset();
    check_outputs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
